alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 114 +++++++++++
 tb/tb_alu_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one external combinational ALU. Each accepted operation
// runs IDLE -> EXEC -> RESP, and the result is held until the owning requester consumes it.
module alu_arbiter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_req0_valid,
   output logic             o_req0_ready,
   input  logic [31:0]      i_req0_opA,
   input  logic [31:0]      i_req0_opB,
   input  logic [3:0]       i_req0_aluOp,
   input  logic             i_req1_valid,
   output logic             o_req1_ready,
   input  logic [31:0]      i_req1_opA,
   input  logic [31:0]      i_req1_opB,
   input  logic [3:0]       i_req1_aluOp,
   output logic             o_rsp0_valid,
   input  logic             i_rsp0_ready,
   output logic             o_rsp1_valid,
   input  logic             i_rsp1_ready,
   output logic [31:0]      o_rspData,
   output logic             o_rspErr,
   output logic [31:0]      o_aluOperandA,
   output logic [31:0]      o_aluOperandB,
   output logic [3:0]       o_aluOp,
   input  logic [31:0]      i_aluData,
   output logic [CNT_W-1:0] o_opCount
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

   state_t            state_q;
   logic [31:0]       opa_q, opb_q, result_q;
   logic [3:0]        op_q;
   logic              owner_q, last_q, err_q;
   logic [CNT_W-1:0]  count_q;
   logic              grant0, grant1, rsp_take;

   // last_q = 1 means port 1 was served last, so port 0 wins the next tie.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_q == StIdle) begin
         grant0 = i_req0_valid && (!i_req1_valid || last_q);
         grant1 = i_req1_valid && (!i_req0_valid || !last_q);
      end
   end

   assign rsp_take = owner_q ? i_rsp1_ready : i_rsp0_ready;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q  <= StIdle;
         opa_q    <= '0;
         opb_q    <= '0;
         op_q     <= '0;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         result_q <= '0;
         err_q    <= 1'b0;
         count_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant0) begin
                  opa_q   <= i_req0_opA;
                  opb_q   <= i_req0_opB;
                  op_q    <= i_req0_aluOp;
                  owner_q <= 1'b0;
                  state_q <= StExec;
               end else if (grant1) begin
                  opa_q   <= i_req1_opA;
                  opb_q   <= i_req1_opB;
                  op_q    <= i_req1_aluOp;
                  owner_q <= 1'b1;
                  state_q <= StExec;
               end
            end
            StExec: begin
               // Codes above lui are illegal: report an error with a zero result.
               if (op_q > 4'd10) begin
                  result_q <= '0;
                  err_q    <= 1'b1;
               end else begin
                  result_q <= i_aluData;
                  err_q    <= 1'b0;
               end
               state_q <= StResp;
            end
            StResp: begin
               if (rsp_take) begin
                  state_q <= StIdle;
                  last_q  <= owner_q;
                  if (count_q != {CNT_W{1'b1}}) count_q <= count_q + CNT_W'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign o_req0_ready  = grant0;
   assign o_req1_ready  = grant1;
   assign o_rsp0_valid  = (state_q == StResp) && !owner_q;
   assign o_rsp1_valid  = (state_q == StResp) && owner_q;
   assign o_rspData     = result_q;
   assign o_rspErr      = err_q;
   assign o_aluOperandA = opa_q;
   assign o_aluOperandB = opb_q;
   assign o_aluOp       = op_q;
   assign o_opCount     = count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, reset-in-flight sequence and random
// transactions checked against a behavioural arbitration/ALU model.
module tb_alu_arbiter;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_req0_valid, i_req1_valid, i_rsp0_ready, i_rsp1_ready;
   logic [31:0] i_req0_opA, i_req0_opB, i_req1_opA, i_req1_opB;
   logic [3:0]  i_req0_aluOp, i_req1_aluOp;

   logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err;
   logic [31:0] rsp_data, alu_a, alu_b, alu_data;
   logic [3:0]  alu_op;
   logic [15:0] op_count;

   logic        req0_ready_b, req1_ready_b, rsp0_valid_b, rsp1_valid_b, rsp_err_b;
   logic [31:0] rsp_data_b, alu_a_b, alu_b_b, alu_data_b;
   logic [3:0]  alu_op_b;
   logic [1:0]  op_count_b;

   int tests = 0;
   int fails = 0;

   logic        last_m;
   int          cnt_m;

   always #5 i_clk = ~i_clk;

   // External ALU; illegal codes return a marker value the DUT must not pass through.
   function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd3:    return (a < b) ? 32'd1 : 32'd0;
         4'd4:    return a ^ b;
         4'd5:    return a | b;
         4'd6:    return a & b;
         4'd7:    return a << b[4:0];
         4'd8:    return a >> b[4:0];
         4'd9:    return $unsigned($signed(a) >>> b[4:0]);
         4'd10:   return b;
         default: return 32'hBADC0DE0;
      endcase
   endfunction

   assign alu_data   = alu_fn(alu_a, alu_b, alu_op);
   assign alu_data_b = alu_fn(alu_a_b, alu_b_b, alu_op_b);

   alu_arbiter dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_req0_valid(i_req0_valid), .o_req0_ready(req0_ready),
      .i_req0_opA(i_req0_opA), .i_req0_opB(i_req0_opB), .i_req0_aluOp(i_req0_aluOp),
      .i_req1_valid(i_req1_valid), .o_req1_ready(req1_ready),
      .i_req1_opA(i_req1_opA), .i_req1_opB(i_req1_opB), .i_req1_aluOp(i_req1_aluOp),
      .o_rsp0_valid(rsp0_valid), .i_rsp0_ready(i_rsp0_ready),
      .o_rsp1_valid(rsp1_valid), .i_rsp1_ready(i_rsp1_ready),
      .o_rspData(rsp_data), .o_rspErr(rsp_err),
      .o_aluOperandA(alu_a), .o_aluOperandB(alu_b), .o_aluOp(alu_op),
      .i_aluData(alu_data), .o_opCount(op_count)
   );

   alu_arbiter #(.CNT_W(2)) dut_b (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_req0_valid(i_req0_valid), .o_req0_ready(req0_ready_b),
      .i_req0_opA(i_req0_opA), .i_req0_opB(i_req0_opB), .i_req0_aluOp(i_req0_aluOp),
      .i_req1_valid(i_req1_valid), .o_req1_ready(req1_ready_b),
      .i_req1_opA(i_req1_opA), .i_req1_opB(i_req1_opB), .i_req1_aluOp(i_req1_aluOp),
      .o_rsp0_valid(rsp0_valid_b), .i_rsp0_ready(i_rsp0_ready),
      .o_rsp1_valid(rsp1_valid_b), .i_rsp1_ready(i_rsp1_ready),
      .o_rspData(rsp_data_b), .o_rspErr(rsp_err_b),
      .o_aluOperandA(alu_a_b), .o_aluOperandB(alu_b_b), .o_aluOp(alu_op_b),
      .i_aluData(alu_data_b), .o_opCount(op_count_b)
   );

   typedef struct {
      logic        v0, v1;
      logic [31:0] a0, b0;
      logic [3:0]  op0;
      logic [31:0] a1, b1;
      logic [3:0]  op1;
      int          hold;
      logic        exp_owner;
      logic [31:0] exp_data;
      logic        exp_err;
   } txn_t;

   txn_t tbl[8];

   function automatic txn_t mk(input logic v0, input logic v1, input logic [31:0] a0,
                               input logic [31:0] b0, input logic [3:0] op0,
                               input logic [31:0] a1, input logic [31:0] b1,
                               input logic [3:0] op1, input int hold, input logic own,
                               input logic [31:0] d, input logic e);
      txn_t t;
      t.v0 = v0; t.v1 = v1; t.a0 = a0; t.b0 = b0; t.op0 = op0;
      t.a1 = a1; t.b1 = b1; t.op1 = op1; t.hold = hold;
      t.exp_owner = own; t.exp_data = d; t.exp_err = e;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      i_req0_valid = 1'b0; i_req1_valid = 1'b0;
      i_rsp0_ready = 1'b0; i_rsp1_ready = 1'b0;
   endtask

   task automatic chk_count();
      chk("op_count", {16'd0, op_count}, cnt_m);
      chk("op_count_w2", {30'd0, op_count_b}, (cnt_m > 3) ? 3 : cnt_m);
   endtask

   // Starts just after a falling edge with the DUT in IDLE.
   task automatic txn(input txn_t t);
      logic [31:0] exp_a;
      logic [3:0]  exp_op;
      i_req0_valid = t.v0; i_req0_opA = t.a0; i_req0_opB = t.b0; i_req0_aluOp = t.op0;
      i_req1_valid = t.v1; i_req1_opA = t.a1; i_req1_opB = t.b1; i_req1_aluOp = t.op1;
      i_rsp0_ready = 1'b0; i_rsp1_ready = 1'b0;
      exp_a  = t.exp_owner ? t.a1 : t.a0;
      exp_op = t.exp_owner ? t.op1 : t.op0;
      #1;
      chk("grant0", {31'd0, req0_ready}, {31'd0, !t.exp_owner});
      chk("grant1", {31'd0, req1_ready}, {31'd0, t.exp_owner});
      @(posedge i_clk);
      @(negedge i_clk);
      // Requester inputs change during EXEC and must be ignored.
      i_req0_valid = 1'b1; i_req0_opA = $urandom; i_req0_aluOp = 4'($urandom);
      i_req1_valid = 1'b1; i_req1_opA = $urandom; i_req1_aluOp = 4'($urandom);
      #1;
      chk("exec_readies", {30'd0, req0_ready, req1_ready}, 32'd0);
      chk("exec_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
      chk("alu_operand_a", alu_a, exp_a);
      chk("alu_op", {28'd0, alu_op}, {28'd0, exp_op});
      @(negedge i_clk);
      #1;
      chk("rsp_valid", {30'd0, rsp1_valid, rsp0_valid},
          t.exp_owner ? 32'd2 : 32'd1);
      chk("rsp_data", rsp_data, t.exp_data);
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, t.exp_err});
      for (int h = 0; h < t.hold; h++) begin
         i_rsp0_ready = t.exp_owner;
         i_rsp1_ready = !t.exp_owner;
         @(negedge i_clk);
         #1;
         chk("hold_valid", {30'd0, rsp1_valid, rsp0_valid}, t.exp_owner ? 32'd2 : 32'd1);
         chk("hold_data", rsp_data, t.exp_data);
         chk("hold_readies", {30'd0, req0_ready, req1_ready}, 32'd0);
      end
      i_rsp0_ready = !t.exp_owner;
      i_rsp1_ready = t.exp_owner;
      @(posedge i_clk);
      last_m = t.exp_owner;
      cnt_m++;
      @(negedge i_clk);
      idle_inputs();
      #1;
      chk("done_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
      chk_count();
   endtask

   task automatic reset_in_exec();
      i_req0_valid = 1'b1; i_req0_opA = 32'd9; i_req0_opB = 32'd4; i_req0_aluOp = 4'd0;
      #1;
      chk("rst_pre_grant", {31'd0, req0_ready}, 32'd1);
      @(posedge i_clk);
      @(negedge i_clk);
      idle_inputs();
      #1;
      chk("rst_pre_operand", alu_a, 32'd9);
      i_reset = 1'b1;
      #1;
      chk("rst_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
      chk("rst_data_err", {rsp_data[30:0], rsp_err}, 32'd0);
      chk("rst_operands", alu_a | alu_b | {28'd0, alu_op}, 32'd0);
      chk("rst_count", {16'd0, op_count}, 32'd0);
      last_m = 1'b1;
      cnt_m  = 0;
      @(negedge i_clk);
      i_reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge i_clk);
         chk("rst_no_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
      end
   endtask

   initial begin
      txn_t r;
      logic [31:0] a, b;
      logic [3:0]  op;
      tbl[0] = mk(1, 0, 32'd5, 32'd3, 4'd1, 0, 0, 0, 0, 0, 32'd2, 0);
      tbl[1] = mk(1, 1, 32'd10, 32'd20, 4'd0, 32'd7, 32'd9, 4'd2, 0, 0, 32'd30, 0);
      tbl[2] = mk(1, 1, 32'd1, 32'd1, 4'd4, 32'hFFFF_FFFF, 32'd1, 4'd2, 1, 1, 32'd1, 0);
      tbl[3] = mk(1, 1, 32'hF0F0_0000, 32'h0FF0_0000, 4'd4, 0, 0, 4'd1, 0, 0,
                  32'hFF00_0000, 0);
      tbl[4] = mk(0, 1, 0, 0, 0, 32'd8, 32'd2, 4'b1100, 0, 1, 32'd0, 1);
      tbl[5] = mk(1, 0, 32'h8000_0000, 32'd4, 4'd9, 0, 0, 0, 5, 0, 32'hF800_0000, 0);
      tbl[6] = mk(1, 0, 32'd3, 32'd3, 4'b1011, 0, 0, 0, 0, 0, 32'd0, 1);
      tbl[7] = mk(0, 1, 0, 0, 0, 32'd1, 32'h1234_5000, 4'd10, 2, 1, 32'h1234_5000, 0);

      idle_inputs();
      i_req0_opA = '0; i_req0_opB = '0; i_req0_aluOp = '0;
      i_req1_opA = '0; i_req1_opB = '0; i_req1_aluOp = '0;
      last_m = 1'b1;
      cnt_m  = 0;
      i_reset = 1'b1;
      repeat (2) @(negedge i_clk);
      i_reset = 1'b0;
      #1;
      chk("reset_outputs", {rsp_data[29:0], rsp0_valid, rsp1_valid}, 32'd0);
      chk("reset_count", {16'd0, op_count}, 32'd0);
      @(negedge i_clk);

      for (int i = 0; i < 8; i++) begin
         if (i == 1) reset_in_exec();
         txn(tbl[i]);
      end

      for (int i = 0; i < 30; i++) begin
         r = mk(1, 1, $urandom, $urandom, 4'($urandom), $urandom, $urandom, 4'($urandom),
                $urandom_range(0, 2), 0, 0, 0);
         case ($urandom_range(0, 2))
            0:       r.v1 = 1'b0;
            1:       r.v0 = 1'b0;
            default: ;
         endcase
         r.exp_owner = (r.v0 && r.v1) ? !last_m : r.v1;
         a  = r.exp_owner ? r.a1 : r.a0;
         b  = r.exp_owner ? r.b1 : r.b0;
         op = r.exp_owner ? r.op1 : r.op0;
         r.exp_err  = (op > 4'd10);
         r.exp_data = r.exp_err ? 32'd0 : alu_fn(a, b, op);
         txn(r);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
